// File: rtl/sm4_out_unpacker_if.sv
// Block-to-word unpacker bus: 128-bit block input side, 32-bit word output side, status.
// Optional WORD_LAST_o present when SM4_UNPACK_LAST_EN is defined.
interface sm4_out_unpacker_if #(
  parameter int DEPTH = 4
);
  logic [127:0]                   DAT_i;
  logic                           DAT_VALID_i;
  logic [31:0]                    WORD_o;
  logic                           WORD_VALID_o;
  logic                           WORD_READY_i;
  logic [$clog2(DEPTH+1)-1:0]     LEVEL_o;
  logic                           OVERFLOW_o;
`ifdef SM4_UNPACK_LAST_EN
  logic                           WORD_LAST_o;
`endif

  modport master (
    output DAT_i, DAT_VALID_i, WORD_READY_i,
    input  WORD_o, WORD_VALID_o, LEVEL_o, OVERFLOW_o
`ifdef SM4_UNPACK_LAST_EN
    , input WORD_LAST_o
`endif
  );

  modport slave (
    input  DAT_i, DAT_VALID_i, WORD_READY_i,
    output WORD_o, WORD_VALID_o, LEVEL_o, OVERFLOW_o
`ifdef SM4_UNPACK_LAST_EN
    , output WORD_LAST_o
`endif
  );
endinterface

// File: rtl/sm4_out_unpacker.sv
// Buffers 128-bit SM4 result blocks in a DEPTH-entry FIFO and streams them out as 32-bit words,
// MSW first. Define SM4_UNPACK_LAST_EN to add WORD_LAST_o (high on the 4th word of a block).
module sm4_out_unpacker #(
  parameter int DEPTH = 4
) (
  input  logic               CLK_i,
  input  logic               RST_N_i,
  sm4_out_unpacker_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

  logic [127:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [1:0]    idx_q, idx_d;
  logic          overflow_q, overflow_d;
  logic          arm_q;

  logic          word_valid, full, xfer, pop, push, drop;
  logic [127:0]  head;
  logic [31:0]   head_word;

  // NOTE: every signal assigned here gets a default first, so no path leaves a latch behind.
  always_comb begin
    word_valid = (level_q != '0);
    full       = (level_q == FULL_LEVEL);
    xfer       = word_valid & bus.WORD_READY_i;
    pop        = xfer & (idx_q == 2'd3);
    push       = arm_q & bus.DAT_VALID_i & (~full | pop);
    drop       = arm_q & bus.DAT_VALID_i & full & ~pop;

    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    idx_d      = idx_q;
    level_d    = level_q;
    overflow_d = overflow_q | drop;

    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    if (xfer) idx_d    = idx_q + 2'd1;

    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // Word select from the head block; depends only on registered state.
  always_comb begin
    head = mem_q[rd_ptr_q];
    case (idx_q)
      2'd0:    head_word = head[127:96];
      2'd1:    head_word = head[95:64];
      2'd2:    head_word = head[63:32];
      default: head_word = head[31:0];
    endcase
  end

  assign bus.WORD_VALID_o = word_valid;
  assign bus.WORD_o       = word_valid ? head_word : 32'h0;
  assign bus.LEVEL_o      = level_q;
  assign bus.OVERFLOW_o   = overflow_q;
`ifdef SM4_UNPACK_LAST_EN
  assign bus.WORD_LAST_o  = word_valid & (idx_q == 2'd3);
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK_i or negedge RST_N_i) begin
    if (!RST_N_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      idx_q      <= '0;
      overflow_q <= 1'b0;
      arm_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      idx_q      <= idx_d;
      overflow_q <= overflow_d;
      // Writes are armed one edge after release, so a pulse on the release edge is never captured.
      arm_q      <= 1'b1;
    end
  end

  // NOTE: the block store has no reset; stale contents are unreachable once level_q is cleared.
  always_ff @(posedge CLK_i) begin
    if (push) mem_q[wr_ptr_q] <= bus.DAT_i;
  end
endmodule
